// File: rtl/mult_sequencer_if.sv
// Multiply request handshake between the requester and mult_sequencer.
interface mult_sequencer_if #(
   parameter int unsigned W = 8
);
   logic           start;
   logic [W-1:0]   a;
   logic [W-1:0]   b;
   logic           busy;
   logic           done;
   logic [2*W-1:0] product;

   modport master (output start, a, b, input busy, done, product);
   modport slave  (input start, a, b, output busy, done, product);
endinterface

// File: rtl/mult_sequencer.sv
// W x W unsigned multiply built by iterating an external 2x2 multiplier over
// all digit pairs and accumulating the shifted 4-bit partial products.
module mult_sequencer #(
   parameter int unsigned W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   mult_sequencer_if.slave  bus,
   output logic [1:0]       mul_a,
   output logic [1:0]       mul_b,
   input  logic [3:0]       mul_p
);

   localparam int unsigned D  = W / 2;
   localparam int unsigned PW = 2 * W;
   localparam int unsigned CW = (D > 1) ? $clog2(D) : 1;
   localparam int unsigned SW = CW + 2;

   typedef enum logic [0:0] {IDLE, CALC} state_e;

   state_e          state_q, state_d;
   logic [W-1:0]    a_r_q, a_r_d;
   logic [W-1:0]    b_r_q, b_r_d;
   logic [CW-1:0]   i_q, i_d;
   logic [CW-1:0]   j_q, j_d;
   logic [PW-1:0]   acc_q, acc_d;
   logic [PW-1:0]   product_q, product_d;
   logic            done_q, done_d;

   logic            last_pair;
   logic [SW-1:0]   shamt;
   logic [PW-1:0]   term;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         a_r_q     <= '0;
         b_r_q     <= '0;
         i_q       <= '0;
         j_q       <= '0;
         acc_q     <= '0;
         product_q <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         a_r_q     <= a_r_d;
         b_r_q     <= b_r_d;
         i_q       <= i_d;
         j_q       <= j_d;
         acc_q     <= acc_d;
         product_q <= product_d;
         done_q    <= done_d;
      end
   end

   assign last_pair = (i_q == CW'(D - 1)) && (j_q == CW'(D - 1));

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.start) state_d = CALC;
         CALC:    if (last_pair) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Partial product weight is 4^(i+j), i.e. a left shift by 2(i+j).
   assign shamt = {(SW - 1)'(i_q) + (SW - 1)'(j_q), 1'b0};
   assign term  = PW'(mul_p) << shamt;

   always_comb begin
      a_r_d     = a_r_q;
      b_r_d     = b_r_q;
      i_d       = i_q;
      j_d       = j_q;
      acc_d     = acc_q;
      product_d = product_q;
      done_d    = 1'b0;
      mul_a     = 2'b00;
      mul_b     = 2'b00;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               a_r_d = bus.a;
               b_r_d = bus.b;
               i_d   = '0;
               j_d   = '0;
               acc_d = '0;
            end
         end
         CALC: begin
            mul_a = a_r_q[{i_q, 1'b0} +: 2];
            mul_b = b_r_q[{j_q, 1'b0} +: 2];
            if (last_pair) begin
               product_d = acc_q + term;
               done_d    = 1'b1;
               acc_d     = '0;
               i_d       = '0;
               j_d       = '0;
            end else begin
               acc_d = acc_q + term;
               if (j_q == CW'(D - 1)) begin
                  j_d = '0;
                  i_d = i_q + CW'(1);
               end else begin
                  j_d = j_q + CW'(1);
               end
            end
         end
         default: ;
      endcase
   end

   assign bus.busy    = (state_q == CALC);
   assign bus.done    = done_q;
   assign bus.product = product_q;

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed bench for mult_sequencer (W=8) with a behavioural 2x2 multiplier.
module tb_mult_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] mul_a, mul_b;
   logic [3:0] mul_p;
   int         n_cmp = 0;
   int         n_err = 0;

   mult_sequencer_if #(.W(8)) ifc ();

   mult_sequencer #(.W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc),
      .mul_a (mul_a),
      .mul_b (mul_b),
      .mul_p (mul_p)
   );

   assign mul_p = {2'b00, mul_a} * {2'b00, mul_b};

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [7:0] av, input logic [7:0] bv);
      ifc.a     = av;
      ifc.b     = bv;
      ifc.start = 1'b1;
      tick();
      ifc.start = 1'b0;
   endtask

   // Advance until done is seen; reports cycles taken, busy cycles and overlap.
   task automatic run_until_done(input int budget, output int lat,
                                 output int busy_cyc, output int overlap);
      lat = 0; busy_cyc = 0; overlap = 0;
      while (ifc.done !== 1'b1 && lat < budget) begin
         if (ifc.busy === 1'b1) busy_cyc++;
         if (ifc.busy === 1'b1 && ifc.done === 1'b1) overlap++;
         tick();
         lat++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; ifc.start = 1'b1; ifc.a = 8'hFF; ifc.b = 8'hFF;
      tick(); tick();
      ifc.start = 1'b0;
      n_cmp++; if (ifc.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", ifc.busy); end
      n_cmp++; if (ifc.done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", ifc.done); end
      n_cmp++; if (ifc.product !== 16'h0000) begin n_err++; $display("FAIL reset_product got %h want 0000", ifc.product); end
      n_cmp++; if (mul_a !== 2'b00 || mul_b !== 2'b00) begin n_err++; $display("FAIL reset_mul got %0d,%0d want 0,0", mul_a, mul_b); end
      rst_n = 1'b1;
      tick();
      n_cmp++; if (ifc.busy !== 1'b0) begin n_err++; $display("FAIL reset_idle_busy got %b want 0", ifc.busy); end
   endtask

   task automatic test_basic(input logic [7:0] av, input logic [7:0] bv, input logic [15:0] exp);
      int lat, bc, ov;
      issue(av, bv);
      n_cmp++; if (ifc.busy !== 1'b1) begin n_err++; $display("FAIL basic_busy_rise got %b want 1", ifc.busy); end
      run_until_done(40, lat, bc, ov);
      n_cmp++; if (lat !== 16) begin n_err++; $display("FAIL basic_latency got %0d want 16", lat); end
      n_cmp++; if (bc !== 16) begin n_err++; $display("FAIL basic_busy_cycles got %0d want 16", bc); end
      n_cmp++; if (ov !== 0 || ifc.busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_done_overlap got %0d/%b want 0/0", ov, ifc.busy); end
      n_cmp++; if (ifc.product !== exp) begin n_err++; $display("FAIL basic_product got %h want %h", ifc.product, exp); end
      tick();
      n_cmp++; if (ifc.done !== 1'b0) begin n_err++; $display("FAIL basic_done_pulse got %b want 0", ifc.done); end
      n_cmp++; if (ifc.product !== exp) begin n_err++; $display("FAIL basic_product_hold got %h want %h", ifc.product, exp); end
   endtask

   task automatic test_digit_sequence();
      logic [7:0] av, bv;
      logic [1:0] ea, eb;
      int bad;
      av = 8'hA5; bv = 8'h3C; bad = 0;
      issue(av, bv);
      for (int n = 0; n < 16; n++) begin
         ea = 2'((av >> (2 * (n / 4))) & 8'h03);
         eb = 2'((bv >> (2 * (n % 4))) & 8'h03);
         if (mul_a !== ea || mul_b !== eb) begin
            bad++;
            $display("FAIL seq_pair[%0d] got (%0d,%0d) want (%0d,%0d)", n, mul_a, mul_b, ea, eb);
         end
         tick();
      end
      n_cmp++; if (bad != 0) n_err++;
      n_cmp++; if (ifc.done !== 1'b1) begin n_err++; $display("FAIL seq_done got %b want 1", ifc.done); end
      n_cmp++; if (ifc.product !== 16'h26AC) begin n_err++; $display("FAIL seq_product got %h want 26ac", ifc.product); end
      n_cmp++; if (mul_a !== 2'b00 || mul_b !== 2'b00) begin n_err++; $display("FAIL seq_idle_mul got %0d,%0d want 0,0", mul_a, mul_b); end
      tick();
   endtask

   task automatic test_start_during_calc();
      int lat, bc, ov, dones;
      issue(8'h12, 8'h34);
      repeat (4) tick();
      issue(8'hFF, 8'hFF);
      run_until_done(40, lat, bc, ov);
      n_cmp++; if (lat !== 11) begin n_err++; $display("FAIL ignore_latency got %0d want 11", lat); end
      n_cmp++; if (ifc.product !== 16'h03A8) begin n_err++; $display("FAIL ignore_product got %h want 03a8", ifc.product); end
      dones = 0; bc = 0;
      for (int n = 0; n < 20; n++) begin
         tick();
         if (ifc.done === 1'b1) dones++;
         if (ifc.busy === 1'b1) bc++;
      end
      n_cmp++; if (dones !== 0 || bc !== 0) begin n_err++; $display("FAIL ignore_extra_done got done=%0d busy=%0d want 0/0", dones, bc); end
   endtask

   task automatic test_reset_mid_calc();
      issue(8'hFF, 8'hFF);
      repeat (7) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      n_cmp++; if (ifc.busy !== 1'b0) begin n_err++; $display("FAIL abort_busy got %b want 0", ifc.busy); end
      n_cmp++; if (ifc.done !== 1'b0) begin n_err++; $display("FAIL abort_done got %b want 0", ifc.done); end
      n_cmp++; if (ifc.product !== 16'h0000) begin n_err++; $display("FAIL abort_product got %h want 0000", ifc.product); end
      n_cmp++; if (mul_a !== 2'b00 || mul_b !== 2'b00) begin n_err++; $display("FAIL abort_mul got %0d,%0d want 0,0", mul_a, mul_b); end
      test_basic(8'h02, 8'h03, 16'h0006);
   endtask

   task automatic test_back_to_back();
      int lat, bc, ov;
      issue(8'h03, 8'h05);
      run_until_done(40, lat, bc, ov);
      n_cmp++; if (ifc.done !== 1'b1 || ifc.product !== 16'h000F) begin n_err++; $display("FAIL b2b_first got done=%b prod=%h want 1/000f", ifc.done, ifc.product); end
      n_cmp++; if (ifc.busy !== 1'b0) begin n_err++; $display("FAIL b2b_done_busy got %b want 0", ifc.busy); end
      issue(8'h07, 8'h09);
      n_cmp++; if (ifc.busy !== 1'b1 || ifc.done !== 1'b0) begin n_err++; $display("FAIL b2b_restart got busy=%b done=%b want 1/0", ifc.busy, ifc.done); end
      n_cmp++; if (ifc.product !== 16'h000F) begin n_err++; $display("FAIL b2b_hold got %h want 000f", ifc.product); end
      run_until_done(40, lat, bc, ov);
      n_cmp++; if (lat !== 16 || bc !== 16) begin n_err++; $display("FAIL b2b_latency got lat=%0d busy=%0d want 16/16", lat, bc); end
      n_cmp++; if (ifc.product !== 16'h003F) begin n_err++; $display("FAIL b2b_second got %h want 003f", ifc.product); end
      tick();
   endtask

   initial begin
      rst_n = 1'b0; ifc.start = 1'b0; ifc.a = '0; ifc.b = '0;
      test_reset();
      test_basic(8'h01, 8'h01, 16'h0001);
      test_basic(8'hFF, 8'hFF, 16'hFE01);
      test_digit_sequence();
      test_start_during_calc();
      test_reset_mid_calc();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mult_sequencer.md
# mult_sequencer

Sequencing controller that computes a W×W-bit unsigned product by iterating the team's 2-bit × 2-bit combinational `multiplier` over all digit pairs. It accumulates the shifted partial products. The block owns the multiplier's A/B inputs and reads its 4-bit output back in the same cycle. It sits between the vital-sign processing logic, which issues multiply requests over a start/busy/done handshake, and the single shared `multiplier` instance.

## Interface
- `W`, default 8: operand width in bits; must be even, range 2..16. D = W/2 digits per operand.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `start` in 1: request a multiply; sampled only in IDLE.
- `a` in W: multiplicand; sampled on the accepting edge only.
- `b` in W: multiplier operand; sampled on the accepting edge only.
- `busy` out 1: high while in CALC.
- `done` out 1: one-cycle pulse marking `product` as newly valid.
- `product` out 2W: unsigned a×b; holds its value until the next `done`.
- `mul_a` out 2: digit driven to `multiplier.A`.
- `mul_b` out 2: digit driven to `multiplier.B`.
- `mul_p` in 4: `multiplier.out`, used combinationally within the cycle.

## Operation
- States: IDLE, CALC.
- Registers:
  - `a_r`, `b_r` (W bits): latched operands.
  - digit counters `i`, `j` (each 0..D-1): `i` indexes `a_r`, `j` indexes `b_r`.
  - `acc` (2W bits).
  - `product`, `done`, state.
- IDLE with `start`=1:
  - latch `a`→`a_r` and `b`→`b_r`.
  - `i`←0, `j`←0, `acc`←0.
  - go to CALC.
- IDLE with `start`=0: hold all state.
- CALC, each cycle:
  - `mul_a` = `a_r[2i+1:2i]`, `mul_b` = `b_r[2j+1:2j]`.
  - `acc` ← `acc` + (`mul_p` zero-extended to 2W) << 2(i+j).
  - `j` increments; when `j` wraps from D-1 to 0, `i` increments.
- Last pair (i=j=D-1):
  - `product` ← `acc` + final term.
  - `done` ← 1.
  - state ← IDLE.
  - counters return to 0.
- Width rule: `acc` is 2W bits; the maximum result, (2^W−1)^2, fits, so there is no overflow and no truncation.
- `mul_a` and `mul_b` are 0 in IDLE.
- `start` while in CALC is ignored; `a` and `b` changes during CALC are ignored.
- `start` in the cycle `done`=1 is accepted, since the state is already IDLE. This gives back-to-back operation with no gap.
- Reset (`rst_n`=0 at any rising edge, including mid-CALC) aborts the operation. It sets:
  - state=IDLE.
  - `busy`=0, `done`=0.
  - `product`=0.
  - `acc`=0, counters=0.
  - `a_r`=0, `b_r`=0.
- Reset wins over `start` on the same edge.

## Timing
- Reset values: `busy`=0, `done`=0, `product`=0, `mul_a`=0, `mul_b`=0.
- `start` accepted at edge k:
  - `busy`=1 from after edge k through edge k+D².
  - `done`=1 for exactly the one cycle after edge k+D².
  - `product` is updated at edge k+D².
- Latency is D² cycles, 16 for W=8; throughput is one result per D² cycles.
- `busy` and `done` are never high in the same cycle.
- `mul_a`/`mul_b` → `mul_p` → `acc` is a single-cycle combinational path through the external multiplier; there are no extra pipeline stages.
- `done` falls after one cycle regardless of `start`.

## Test plan
1. W=8, reset, then `a`=0x01, `b`=0x01, `start` for one cycle → `busy` high 16 cycles; `done` pulses once; `product`=0x0001.
2. `a`=0xFF, `b`=0xFF → `product`=0xFE01 after 16 cycles. Covers the maximum value with no overflow.
3. `a`=0xA5, `b`=0x3C → `product`=0x26AC. Also check the CALC sequence of (`mul_a`,`mul_b`) pairs: (1,0),(1,3),(1,3),(1,0),(1,0),… in `i`-major order.
4. Start 0x12×0x34. At cycle 5 of CALC, pulse `start` with `a`=0xFF, `b`=0xFF → the second request is ignored; `product`=0x03A8; exactly one `done`.
5. Start 0xFF×0xFF and drive `rst_n`=0 for one edge at cycle 8 of CALC → the next cycle shows `busy`=0, `done`=0, `product`=0. A subsequent 0x02×0x03 yields 0x0006.
6. Start 0x03×0x05, then assert `start` with 0x07×0x09 in the `done` cycle → `product` is 0x000F, then 0x003F exactly 16 cycles later; `busy` stays 0 only during the single `done` cycle.
